// File: rtl/s3g_tx_pkg.sv
// S3G transmit framer shared definitions: sync byte default, FSM encoding, CRC8 step.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package s3g_tx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hD5;

  // Names match the receiver's S_* set where they coincide
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SYNC      = 3'd1,
    S_LEN       = 3'd2,
    S_DATA      = 3'd3,
    S_CRC       = 3'd4,
    S_WAIT_LAST = 3'd5
  } state_t;

  // One byte of Maxim/iButton CRC8 (x^8+x^5+x^4+1, reflected, LSB first)
  function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_tx_buffer.sv
// 256x8 simple dual-port payload RAM: synchronous write, registered read.
// Latency: read data appears 1 cycle after rd_addr; a same-address write in that cycle returns old data.
// Backpressure: none; writes and reads are accepted every cycle.
module s3g_tx_buffer (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [256];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port (read-before-write on address collision)
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/s3g_tx.sv
// S3G transmit framer: sends SYNC, LEN, payload, CRC8 through a tx_wr/tx_done byte handshake.
// Latency: SYNC issued 1 cycle after accepted start; each further byte 1 cycle after tx_done.
// Backpressure: paced entirely by tx_done; start is ignored while busy (no queueing).
module s3g_tx
  import s3g_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [7:0] payload_len,
  output logic       busy,
  output logic       packet_sent,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done
);

  state_t     state, state_d;
  logic [7:0] len, len_d;
  logic [7:0] byte_cnt, byte_cnt_d;
  logic [7:0] rd_ptr, rd_ptr_d;
  logic [7:0] crc, crc_d;
  logic [7:0] tx_data_d;
  logic       tx_wr_d;
  logic       packet_sent_d;
  logic [7:0] stage;
  logic       done_ok;

  // Buffer output is the prefetched next payload byte: the pointer advances at each
  // issue, so the following byte is ready long before the current one finishes.
  s3g_tx_buffer u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (stage)
  );

  // A tx_done coinciding with our own write pulse cannot belong to the new byte
  assign done_ok = tx_done && !tx_wr;
  assign busy    = (state != S_IDLE);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    len_d         = len;
    byte_cnt_d    = byte_cnt;
    rd_ptr_d      = rd_ptr;
    crc_d         = crc;
    tx_data_d     = tx_data;
    tx_wr_d       = 1'b0;
    packet_sent_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          len_d      = payload_len;
          byte_cnt_d = payload_len;
          crc_d      = 8'h00;
          rd_ptr_d   = 8'h00;
          tx_data_d  = SYNC_BYTE;
          tx_wr_d    = 1'b1;
          state_d    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (done_ok) begin
          tx_data_d = len;
          tx_wr_d   = 1'b1;
          state_d   = S_LEN;
        end
      end
      S_LEN, S_DATA: begin
        if (done_ok) begin
          tx_wr_d = 1'b1;
          if (byte_cnt != 8'h00) begin
            tx_data_d  = stage;
            crc_d      = nextCRC8_D8(stage, crc);
            rd_ptr_d   = rd_ptr + 8'd1;
            byte_cnt_d = byte_cnt - 8'd1;
            state_d    = S_DATA;
          end else begin
            tx_data_d = crc;
            state_d   = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (done_ok) begin
          packet_sent_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len         <= 8'h00;
      byte_cnt    <= 8'h00;
      rd_ptr      <= 8'h00;
      crc         <= 8'h00;
      tx_data     <= 8'h00;
      tx_wr       <= 1'b0;
      packet_sent <= 1'b0;
    end else begin
      state       <= state_d;
      len         <= len_d;
      byte_cnt    <= byte_cnt_d;
      rd_ptr      <= rd_ptr_d;
      crc         <= crc_d;
      tx_data     <= tx_data_d;
      tx_wr       <= tx_wr_d;
      packet_sent <= packet_sent_d;
    end
  end

endmodule

// File: tb/tb_s3g_tx.sv
// Testbench for s3g_tx: random payloads and UART pacing against a frame-level reference.
// Latency: checks 1-cycle issue after start/tx_done and packet_sent after the CRC byte.
// Backpressure: the bench plays the UART, returning tx_done after a random delay.
module tb_s3g_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [7:0] payload_len;
  logic       busy;
  logic       packet_sent;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [256];
  logic [7:0] got_q [$];

  s3g_tx #(.SYNC_BYTE(8'hD5)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .payload_len (payload_len),
    .busy        (busy),
    .packet_sent (packet_sent),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs set after this are seen at the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial Dallas CRC8 over a whole payload
  function automatic logic [7:0] ref_crc(input logic [7:0] q [$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  task automatic write_buf(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr[7:0];
    wr_data = data;
    model_mem[addr] = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Send one frame, acting as the UART; rst_idx >= 0 resets at that byte's issue cycle
  task automatic run_frame(input int len, input bit poke, input bit spur, input int rst_idx);
    logic [7:0] exp_q [$];
    logic [7:0] pl [$];
    int         n;
    got_q.delete();
    for (int i = 0; i < len; i++) pl.push_back(model_mem[i]);
    exp_q.push_back(8'hD5);
    exp_q.push_back(len[7:0]);
    foreach (pl[i]) exp_q.push_back(pl[i]);
    exp_q.push_back(ref_crc(pl));

    start       = 1'b1;
    payload_len = len[7:0];
    tick();
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check("issue_wr", int'(tx_wr), 1);
      check("issue_data", int'(tx_data), int'(exp_q[k]));
      check("issue_busy", int'(busy), 1);
      check("sent_early", int'(packet_sent), 0);
      got_q.push_back(tx_data);
      if (k == rst_idx) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wr", int'(tx_wr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sent", int'(packet_sent), 0);
        repeat (3) begin
          tx_done = 1'b1;
          tick();
          tx_done = 1'b0;
          check("rst_late_wr", int'(tx_wr), 0);
          check("rst_late_sent", int'(packet_sent), 0);
          check("rst_late_busy", int'(busy), 0);
        end
        return;
      end
      tx_done = spur;
      tick();
      tx_done = 1'b0;
      check("gap_wr", int'(tx_wr), 0);
      n = $urandom_range(0, 3);
      repeat (n) begin
        start       = poke;
        payload_len = 8'($urandom);
        tick();
        start = 1'b0;
        check("gap_wr", int'(tx_wr), 0);
        check("gap_busy", int'(busy), 1);
        check("gap_sent", int'(packet_sent), 0);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    check("sent_pulse", int'(packet_sent), 1);
    check("done_busy", int'(busy), 0);
    check("done_wr", int'(tx_wr), 0);
  endtask

  initial begin
    int len;
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = 8'h00;
    wr_data     = 8'h00;
    start       = 1'b0;
    payload_len = 8'h00;
    tx_done     = 1'b0;
    tick();
    tick();
    check("rst_busy0", int'(busy), 0);
    check("rst_wr0", int'(tx_wr), 0);
    check("rst_data0", int'(tx_data), 0);
    check("rst_sent0", int'(packet_sent), 0);
    rst = 1'b0;
    tick();

    // Stray tx_done while idle must not start anything
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("idle_done_wr", int'(tx_wr), 0);
    check("idle_done_busy", int'(busy), 0);
    tick();
    check("idle_done_wr2", int'(tx_wr), 0);

    // Empty payload: D5 00 00
    run_frame(0, 1'b0, 1'b0, -1);
    check("len0_count", got_q.size(), 3);
    tick();

    // Single byte 01: CRC must be 5E
    write_buf(0, 8'h01);
    run_frame(1, 1'b0, 1'b1, -1);
    check("crc_01", int'(got_q[3]), 'h5E);

    // Full-length frame 00..FE, then a back-to-back frame on the packet_sent cycle
    for (int i = 0; i < 255; i++) write_buf(i, i[7:0]);
    run_frame(255, 1'b1, 1'b1, -1);
    check("len255_count", got_q.size(), 258);
    run_frame(2, 1'b1, 1'b0, -1);

    // Random payloads, lengths and pacing
    repeat (8) begin
      len = $urandom_range(0, 24);
      for (int i = 0; i < len; i++) write_buf(i, 8'($urandom));
      run_frame(len, 1'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Reset in the middle of the payload, then a fresh correct frame
    for (int i = 0; i < 10; i++) write_buf(i, 8'($urandom));
    run_frame(10, 1'b0, 1'b0, 5);
    tick();
    run_frame(10, 1'b1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s3g_tx.md
# s3g_tx

Packet framer on the transmit side of the S3G link. It holds a 256-byte payload buffer filled by host logic. On `start` it serialises one framed packet (sync byte, length, payload, CRC8) into the UART transmitter's `tx_data`/`tx_wr`/`tx_done` byte handshake. It is the transmit-side counterpart of the S3G receiver and produces the same frame format that receiver accepts.

## Interface
- `SYNC_BYTE`, default 8'hD5: frame start byte.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  payload buffer write strobe.
- `wr_addr`  in  8  payload buffer write address.
- `wr_data`  in  8  payload buffer write data.
- `start`  in  1  one-cycle request to send a packet; accepted only when `busy`=0.
- `payload_len`  in  8  payload byte count, 0..255; sampled on the accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the packet completes.
- `packet_sent`  out  1  one-cycle pulse when the CRC byte has completed.
- `tx_data`  out  8  byte to UART; valid while `tx_wr`=1 and held until the next issue.
- `tx_wr`  out  1  one-cycle write pulse to UART.
- `tx_done`  in  1  UART pulse: the current byte has finished shifting out.
- One clock; reset is synchronous and active-high (ports `clk`, `rst`).

## Operation
- States: IDLE, SYNC, LEN, DATA, CRC, WAIT_LAST.
- IDLE: on `start`:
  - latch `payload_len` into `len` and `byte_cnt`;
  - clear `crc` to 0;
  - set read pointer to 0;
  - issue SYNC_BYTE (`tx_wr`=1) and go to SYNC.
- SYNC: on `tx_done`, issue `len` and go to LEN.
- LEN: on `tx_done`:
  - if `len`=0, issue `crc` (=0) and go to CRC;
  - otherwise issue buffer[0], update `crc`, and go to DATA.
- DATA: on `tx_done`:
  - if bytes remain, issue the next prefetched buffer byte and update `crc`;
  - after the last payload byte, issue `crc` and go to CRC.
- CRC update: `crc <= nextCRC8_D8(byte, crc)` on each payload byte at issue time (Maxim/iButton CRC8, shared `crc8.v`). Init 0. Sync and length bytes are excluded.
- CRC: on `tx_done`, pulse `packet_sent`, drop `busy`, return to IDLE.
- WAIT_LAST is unused in normal flow. Any illegal state goes to IDLE.
- Prefetch: the next payload byte is read from the buffer and registered in `stage` while the current byte shifts. Every issue is therefore exactly 1 cycle after `tx_done`.
- Buffer writes are accepted at any time.
  - Writes while `busy`=1 give unspecified content for that packet.
  - Write/read to the same address in the same cycle returns the old data.
- `start` while `busy`=1 is ignored; no queueing.
- `tx_done` in IDLE, or in the same cycle as `tx_wr`, is ignored.
- Reset values: `busy`=0, `packet_sent`=0, `tx_wr`=0, `tx_data`=0, state IDLE, `crc`=0. Buffer contents are not reset.
- Reset mid-packet: the next cycle is IDLE with `tx_wr`=0 and no `packet_sent`. The UART may still finish the byte in flight.

## Timing
- `start` accepted at cycle N: `tx_wr`=1 with `tx_data`=SYNC_BYTE and `busy`=1 at N+1.
- `tx_done` at cycle M: next byte's `tx_wr` pulse at M+1.
- Final `tx_done` at M: `packet_sent`=1 and `busy`=0 at M+1.
- A `start` in that M+1 cycle is accepted; back-to-back packets have no gap beyond 1 cycle.
- Buffer read latency is 1 cycle, registered, and fully hidden by prefetch.
- Bytes per packet = `len` + 3. `byte_cnt` is 8-bit; `len`=255 sends 258 bytes with no wrap in the pointer.

## Structure
- Shared package/header:
  - `SYNC_BYTE` default;
  - state encodings (shared with the receiver's S_* set where names coincide);
  - the `nextCRC8_D8` function via `crc8.v`.
- One sub-module, `s3g_tx_buffer`: 256×8 simple dual-port RAM, synchronous write, registered read, block-RAM inferable.
- The top FSM holds the counters, CRC and UART handshake.

## Test plan
- `len`=0, `start` → bytes D5, 00, 00; one `packet_sent`; `busy` high 3 byte-times.
- Buffer {01}, `len`=1 → D5, 01, 01, 5E; each `tx_wr` 1 cycle after the previous `tx_done`.
- Buffer 00..FE, `len`=255 → 258 bytes, payload in order, CRC matches reference model; `packet_sent` once.
- `start` pulsed while `busy` → ignored, byte stream unchanged. `start` on the `packet_sent` cycle → new D5 1 cycle later.
- `rst` asserted during DATA → `tx_wr`=0 and `busy`=0 next cycle; no `packet_sent`. A fresh `start` then produces a correct frame.
- Spurious `tx_done` in IDLE and coincident with `tx_wr` → no extra bytes, no state change.
